accuracy_window_monitor: RTL and testbench
==========================================

Name: accuracy_window_monitor

Overview:
- Synthesizable on-chip successor to the bench-side accuracy bookkeeping used in DNN training runs.
- Taps the output-layer stream of the DNN, p neurons per clock, and decides per training case whether the network was correct.
- Keeps a sliding-window count over the last `window` cases, a per-epoch count, a cumulative count, and case/epoch counters.
- Supports two scoring modes, exact thresholded match and argmax classification, so accuracy is available without a simulator.

Parameters:
- n_out, 16: output neurons per case; must be a multiple of p.
- p, 1: neurons presented per valid beat.
- width, 12: bit width of each raw activation.
- mode, 0: 0 = exact match of all thresholded bits; 1 = argmax over classes.
- n_class, 10: neurons 0..n_class-1 take part in argmax; requires n_class <= n_out.
- window, 1000: sliding-window depth in cases.
- cases_per_epoch, 10000: cases per epoch.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  beat carries p neurons of the current case.
- a_bits  in  p  thresholded actual outputs; bit k is neuron beat*p+k.
- y_bits  in  p  ideal one-hot outputs, same ordering as a_bits.
- act  in  p*width  raw unsigned activations, lane k in bits [k*width+:width].
- result_valid  out  1  one-cycle pulse: case result is available.
- correct  out  1  result of the last completed case.
- recent  out  $clog2(window+1)  correct count within the window.
- window_full  out  1  at least `window` cases have completed since reset.
- epoch_correct  out  32  correct count in the current epoch.
- total_correct  out  32  cumulative correct count.
- num_cases  out  32  completed cases.
- epoch  out  16  current epoch number; first epoch is 1.
- epoch_done  out  1  one-cycle pulse with the result_valid that closes an epoch.

Behaviour:
- **Reset values:** all outputs 0 except epoch = 1. Beat counter 0, window bits 0, window pointer 0, argmax state cleared.
- **Reset mid-case:** the partial case is discarded and nothing is reported.
- **Case framing:** B = n_out/p beats per case.
  - The beat counter advances only on in_valid and wraps B-1 -> 0.
  - Gaps on in_valid are legal; state holds through them.
- **Mode 0:** mismatch flag is ORed each beat with |(a_bits ^ y_bits). correct = ~mismatch.
- **Mode 1:**
  - Running max is compared over lanes with global index < n_class; strict `>` is used, so ties keep the lower index.
  - y_idx is the lowest index with y_bits set, within n_class.
  - correct = (max_idx == y_idx) and y_found. A case with no y set is incorrect.
- **Per-case state:** the mismatch flag and the argmax state are reinitialised on the first beat of each case.
- **Latency:** the last beat is accepted at cycle T. At T+1:
  - result_valid = 1; correct, counters and window update together.
  - num_cases increments; total_correct and epoch_correct add correct.
- **Window:**
  - recent <= recent - buf[ptr] + correct; buf[ptr] <= correct.
  - ptr wraps window-1 -> 0.
  - window_full sets when ptr wraps for the first time and stays set.
  - recent never exceeds window.
- **Epoch:** an internal case-in-epoch counter wraps at cases_per_epoch. On the wrap:
  - epoch_done pulses with result_valid;
  - epoch increments;
  - epoch_correct takes 0 from the next cycle, after showing its final value during the pulse cycle.
- **Overlap:** the first beat of the next case may arrive at T+1, concurrently with the result update. No stall is inserted.
- **Counter overflow:** 32-bit counters wrap modulo 2^32. epoch wraps modulo 2^16.

Test Plan:
- Mode 0, n_out=16, p=1, window=4. Feed 16 beats with a_bits == y_bits -> result_valid pulses exactly 1 cycle after beat 15; correct=1, recent=1, num_cases=1.
- Mode 0. One case with neuron 7 mismatched, then 5 matching cases (window=4) -> recent sequence 0,1,2,3,4,4; window_full=1 from the 4th result onward.
- Mode 1, n_class=10, p=4. act max at index 3, y one-hot at 3, index 12 holding the highest value overall -> correct=1 (index 12 is excluded). With a tie at indices 3 and 5 and y=5 -> correct=0.
- cases_per_epoch=3, all cases correct -> epoch_done on the 3rd result; epoch goes 1->2; epoch_correct reads 3 in that cycle, then 0; total_correct keeps counting 4, 5, ...
- Assert reset after 6 of 16 beats, then feed a full case -> exactly one result_valid, num_cases=1, epoch=1.
- in_valid toggled 1/0 every cycle during a case -> result identical to the gap-free case; result_valid lands 1 cycle after the 16th valid beat.

Source files
------------

// File: rtl/accuracy_window_monitor.sv
// Scores each DNN training case from the output-layer stream (exact match or argmax)
// and keeps sliding-window, per-epoch and cumulative correct counts.
module accuracy_window_monitor #(
    parameter int n_out           = 16,
    parameter int p               = 1,
    parameter int width           = 12,
    parameter int mode            = 0,
    parameter int n_class         = 10,
    parameter int window          = 1000,
    parameter int cases_per_epoch = 10000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [p-1:0]                 a_bits,
    input  logic [p-1:0]                 y_bits,
    input  logic [p*width-1:0]           act,
    output logic                         result_valid,
    output logic                         correct,
    output logic [$clog2(window+1)-1:0]  recent,
    output logic                         window_full,
    output logic [31:0]                  epoch_correct,
    output logic [31:0]                  total_correct,
    output logic [31:0]                  num_cases,
    output logic [15:0]                  epoch,
    output logic                         epoch_done
);

    localparam int beats = n_out / p;
    localparam int bw    = (beats > 1) ? $clog2(beats) : 1;
    localparam int iw    = (n_out > 1) ? $clog2(n_out) : 1;
    localparam int rw    = $clog2(window + 1);
    localparam int pw    = (window > 1) ? $clog2(window) : 1;
    localparam int cw    = (cases_per_epoch > 1) ? $clog2(cases_per_epoch) : 1;

    logic [bw-1:0]    beat_q, beat_d;
    logic             mismatch_q, mismatch_d;
    logic [width-1:0] max_val_q, max_val_d;
    logic [iw-1:0]    max_idx_q, max_idx_d;
    logic [iw-1:0]    y_idx_q, y_idx_d;
    logic             y_found_q, y_found_d;
    logic             last_beat, case_correct;
    logic [width-1:0] lane;
    int               gidx;

    logic             result_valid_q, result_valid_d;
    logic             correct_q, correct_d;
    logic [rw-1:0]    recent_q, recent_d;
    logic             window_full_q, window_full_d;
    logic [window-1:0] win_q, win_d;
    logic [pw-1:0]    ptr_q, ptr_d;
    logic [cw-1:0]    cie_q, cie_d;
    logic [31:0]      epoch_correct_q, epoch_correct_d, ecorr_base;
    logic [31:0]      total_correct_q, total_correct_d;
    logic [31:0]      num_cases_q, num_cases_d;
    logic [15:0]      epoch_q, epoch_d;
    logic             epoch_done_q, epoch_done_d;

    // Per-case scoring: state restarts on the first beat so the last beat's _d values
    // already hold the full-case verdict.
    always_comb begin
        beat_d     = beat_q;
        mismatch_d = mismatch_q;
        max_val_d  = max_val_q;
        max_idx_d  = max_idx_q;
        y_idx_d    = y_idx_q;
        y_found_d  = y_found_q;
        lane       = '0;
        gidx       = 0;
        last_beat  = in_valid && (beat_q == bw'(beats - 1));
        if (in_valid) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
            if (beat_q == '0) begin
                mismatch_d = 1'b0;
                max_val_d  = '0;
                max_idx_d  = '0;
                y_idx_d    = '0;
                y_found_d  = 1'b0;
            end
            mismatch_d = mismatch_d | (|(a_bits ^ y_bits));
            for (int k = 0; k < p; k++) begin
                gidx = int'(beat_q) * p + k;
                lane = act[k*width +: width];
                if (gidx < n_class) begin
                    // Strict compare against a zero seed at index 0 keeps ties on the lower index.
                    if (lane > max_val_d) begin
                        max_val_d = lane;
                        max_idx_d = iw'(gidx);
                    end
                    if (y_bits[k] && !y_found_d) begin
                        y_found_d = 1'b1;
                        y_idx_d   = iw'(gidx);
                    end
                end
            end
        end
        if (mode == 1) case_correct = y_found_d && (max_idx_d == y_idx_d);
        else           case_correct = ~mismatch_d;
    end

    always_comb begin
        result_valid_d  = last_beat;
        correct_d       = correct_q;
        recent_d        = recent_q;
        window_full_d   = window_full_q;
        win_d           = win_q;
        ptr_d           = ptr_q;
        cie_d           = cie_q;
        total_correct_d = total_correct_q;
        num_cases_d     = num_cases_q;
        epoch_d         = epoch_q;
        epoch_done_d    = 1'b0;
        // The closing epoch count stays visible for the pulse cycle, then restarts.
        ecorr_base      = epoch_done_q ? '0 : epoch_correct_q;
        epoch_correct_d = ecorr_base;
        if (last_beat) begin
            correct_d       = case_correct;
            num_cases_d     = num_cases_q + 32'd1;
            total_correct_d = total_correct_q + {31'd0, case_correct};
            epoch_correct_d = ecorr_base + {31'd0, case_correct};
            recent_d        = recent_q - rw'(win_q[ptr_q]) + rw'(case_correct);
            win_d[ptr_q]    = case_correct;
            if (ptr_q == pw'(window - 1)) begin
                ptr_d         = '0;
                window_full_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
            if (cie_q == cw'(cases_per_epoch - 1)) begin
                cie_d        = '0;
                epoch_done_d = 1'b1;
                epoch_d      = epoch_q + 16'd1;
            end else begin
                cie_d = cie_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q          <= '0;
            mismatch_q      <= 1'b0;
            max_val_q       <= '0;
            max_idx_q       <= '0;
            y_idx_q         <= '0;
            y_found_q       <= 1'b0;
            result_valid_q  <= 1'b0;
            correct_q       <= 1'b0;
            recent_q        <= '0;
            window_full_q   <= 1'b0;
            // NOTE: the window history must be cleared, otherwise recent would subtract stale bits.
            win_q           <= '0;
            ptr_q           <= '0;
            cie_q           <= '0;
            epoch_correct_q <= '0;
            total_correct_q <= '0;
            num_cases_q     <= '0;
            epoch_q         <= 16'd1;
            epoch_done_q    <= 1'b0;
        end else begin
            beat_q          <= beat_d;
            mismatch_q      <= mismatch_d;
            max_val_q       <= max_val_d;
            max_idx_q       <= max_idx_d;
            y_idx_q         <= y_idx_d;
            y_found_q       <= y_found_d;
            result_valid_q  <= result_valid_d;
            correct_q       <= correct_d;
            recent_q        <= recent_d;
            window_full_q   <= window_full_d;
            win_q           <= win_d;
            ptr_q           <= ptr_d;
            cie_q           <= cie_d;
            epoch_correct_q <= epoch_correct_d;
            total_correct_q <= total_correct_d;
            num_cases_q     <= num_cases_d;
            epoch_q         <= epoch_d;
            epoch_done_q    <= epoch_done_d;
        end
    end

    assign result_valid  = result_valid_q;
    assign correct       = correct_q;
    assign recent        = recent_q;
    assign window_full   = window_full_q;
    assign epoch_correct = epoch_correct_q;
    assign total_correct = total_correct_q;
    assign num_cases     = num_cases_q;
    assign epoch         = epoch_q;
    assign epoch_done    = epoch_done_q;

endmodule

// File: tb/tb_accuracy_window_monitor.sv
// Bench for accuracy_window_monitor: an exact-match instance (p=1) and an argmax
// instance (p=4), both checked every cycle against a case-level reference model.
module tb_accuracy_window_monitor;

    localparam int N_OUT  = 16;
    localparam int W      = 12;
    localparam int WIN    = 4;
    localparam int CPE    = 3;
    localparam int NCLASS = 10;

    typedef struct packed {
        logic [N_OUT-1:0]   a;
        logic [N_OUT-1:0]   y;
        logic [N_OUT*W-1:0] act;
    } case_t;

    logic clk, reset;

    logic           in_valid0, a0, y0;
    logic [W-1:0]   act0;
    logic           rv0, corr0, wf0, ed0;
    logic [2:0]     recent0;
    logic [31:0]    ec0, tc0, nc0;
    logic [15:0]    ep0;

    logic           in_valid1;
    logic [3:0]     a1, y1;
    logic [4*W-1:0] act1;
    logic           rv1, corr1, wf1, ed1;
    logic [2:0]     recent1;
    logic [31:0]    ec1, tc1, nc1;
    logic [15:0]    ep1;

    accuracy_window_monitor #(.n_out(N_OUT), .p(1), .width(W), .mode(0), .n_class(NCLASS),
                              .window(WIN), .cases_per_epoch(CPE)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .a_bits(a0), .y_bits(y0), .act(act0),
        .result_valid(rv0), .correct(corr0), .recent(recent0), .window_full(wf0),
        .epoch_correct(ec0), .total_correct(tc0), .num_cases(nc0), .epoch(ep0), .epoch_done(ed0));

    accuracy_window_monitor #(.n_out(N_OUT), .p(4), .width(W), .mode(1), .n_class(NCLASS),
                              .window(WIN), .cases_per_epoch(CPE)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .a_bits(a1), .y_bits(y1), .act(act1),
        .result_valid(rv1), .correct(corr1), .recent(recent1), .window_full(wf1),
        .epoch_correct(ec1), .total_correct(tc1), .num_cases(nc1), .epoch(ep1), .epoch_done(ed1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one entry per DUT, updated once per completed case.
    int unsigned m_num[2], m_total[2], m_ecorr[2], m_cie[2];
    logic [15:0] m_epoch[2];
    bit          m_rv[2], m_ed[2], m_corr[2], m_clear[2];
    bit          hist0[$], hist1[$];

    function automatic bit model_correct(input int d, input case_t c);
        int best, yi;
        logic [W-1:0] bv, v;
        if (d == 0) return (c.a == c.y);
        best = 0;
        bv   = c.act[0 +: W];
        for (int i = 1; i < NCLASS; i++) begin
            v = c.act[i*W +: W];
            if (v > bv) begin
                bv   = v;
                best = i;
            end
        end
        yi = -1;
        for (int i = NCLASS - 1; i >= 0; i--) if (c.y[i]) yi = i;
        return (yi >= 0) && (yi == best);
    endfunction

    function automatic int hist_sum(input int d);
        int s = 0;
        if (d == 0) foreach (hist0[i]) s += int'(hist0[i]);
        else        foreach (hist1[i]) s += int'(hist1[i]);
        return s;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_num[d] = 0; m_total[d] = 0; m_ecorr[d] = 0; m_cie[d] = 0;
            m_epoch[d] = 16'd1;
            m_rv[d] = 0; m_ed[d] = 0; m_corr[d] = 0; m_clear[d] = 0;
        end
        hist0.delete();
        hist1.delete();
    endtask

    task automatic model_commit(input int d, input bit c);
        m_rv[d]    = 1'b1;
        m_corr[d]  = c;
        m_num[d]   = m_num[d] + 1;
        m_total[d] = m_total[d] + c;
        m_ecorr[d] = m_ecorr[d] + c;
        if (d == 0) begin
            hist0.push_back(c);
            if (hist0.size() > WIN) void'(hist0.pop_front());
        end else begin
            hist1.push_back(c);
            if (hist1.size() > WIN) void'(hist1.pop_front());
        end
        m_cie[d] = m_cie[d] + 1;
        if (m_cie[d] == CPE) begin
            m_cie[d]   = 0;
            m_ed[d]    = 1'b1;
            m_epoch[d] = m_epoch[d] + 16'd1;
            m_clear[d] = 1'b1;
        end
    endtask

    task automatic cmp_dut(input int d, input logic rv, input logic cr, input logic [31:0] rc,
                           input logic wf, input logic [31:0] ec, input logic [31:0] tc,
                           input logic [31:0] nc, input logic [15:0] ep, input logic ed);
        check($sformatf("d%0d result_valid", d), {31'd0, rv}, {31'd0, m_rv[d]});
        check($sformatf("d%0d correct", d), {31'd0, cr}, {31'd0, m_corr[d]});
        check($sformatf("d%0d recent", d), rc, hist_sum(d));
        check($sformatf("d%0d window_full", d), {31'd0, wf}, (m_num[d] >= WIN) ? 32'd1 : 32'd0);
        check($sformatf("d%0d epoch_correct", d), ec, m_ecorr[d]);
        check($sformatf("d%0d total_correct", d), tc, m_total[d]);
        check($sformatf("d%0d num_cases", d), nc, m_num[d]);
        check($sformatf("d%0d epoch", d), {16'd0, ep}, {16'd0, m_epoch[d]});
        check($sformatf("d%0d epoch_done", d), {31'd0, ed}, {31'd0, m_ed[d]});
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_dut(0, rv0, corr0, 32'(recent0), wf0, ec0, tc0, nc0, ep0, ed0);
            cmp_dut(1, rv1, corr1, 32'(recent1), wf1, ec1, tc1, nc1, ep1, ed1);
            for (int d = 0; d < 2; d++) begin
                m_rv[d] = 1'b0;
                m_ed[d] = 1'b0;
                if (m_clear[d]) begin
                    m_ecorr[d] = 0;
                    m_clear[d] = 1'b0;
                end
            end
        end
    end

    task automatic idle_inputs(input int d);
        if (d == 0) begin
            in_valid0 = 1'b0; a0 = 1'($urandom); y0 = 1'($urandom); act0 = W'($urandom);
        end else begin
            in_valid1 = 1'b0; a1 = 4'($urandom); y1 = 4'($urandom); act1 = (4*W)'({$urandom, $urandom});
        end
    endtask

    task automatic send_case(input int d, input case_t c, input int gap_pct);
        int nb;
        nb = (d == 0) ? 16 : 4;
        for (int b = 0; b < nb; b++) begin
            if (d == 0) begin
                in_valid0 = 1'b1; a0 = c.a[b]; y0 = c.y[b]; act0 = c.act[b*W +: W];
            end else begin
                in_valid1 = 1'b1; a1 = c.a[b*4 +: 4]; y1 = c.y[b*4 +: 4]; act1 = c.act[b*4*W +: 4*W];
            end
            @(posedge clk); #1;
            if (b == nb - 1) begin
                model_commit(d, model_correct(d, c));
                idle_inputs(d);
            end else if (int'($urandom_range(99)) < gap_pct) begin
                idle_inputs(d);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic do_reset();
        cmp_en = 1'b0;
        reset  = 1'b1;
        idle_inputs(0);
        idle_inputs(1);
        @(posedge clk); #1;
        model_reset();
        @(posedge clk); #1;
        reset  = 1'b0;
        cmp_en = 1'b1;
    endtask

    function automatic case_t match_case();
        case_t c;
        c.act = '0;
        c.y   = 16'(1) << $urandom_range(15);
        c.a   = c.y;
        return c;
    endfunction

    function automatic case_t rand_case(input int d);
        case_t c;
        int best;
        logic [W-1:0] bv;
        for (int i = 0; i < N_OUT; i++)
            c.act[i*W +: W] = (d == 1) ? W'($urandom_range(15)) : W'($urandom);
        c.y = 16'(1) << $urandom_range(15);
        if (d == 1 && $urandom_range(1) == 1) begin
            best = 0;
            bv   = c.act[0 +: W];
            for (int i = 1; i < NCLASS; i++)
                if (c.act[i*W +: W] > bv) begin bv = c.act[i*W +: W]; best = i; end
            c.y = 16'(1) << best;
        end
        if (d == 1 && $urandom_range(9) == 0) c.y = '0;
        c.a = c.y;
        if ($urandom_range(1) == 1) c.a = c.a ^ (16'(1) << $urandom_range(15));
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int    exp_recent[6] = '{0, 1, 2, 3, 4, 4};
    int    exp_full[6]   = '{0, 0, 0, 1, 1, 1};
    case_t c;

    initial begin
        reset = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        do_reset();

        @(negedge clk);
        check("reset num_cases", nc0, 32'd0);
        check("reset epoch", {16'd0, ep0}, 32'd1);
        check("reset recent", 32'(recent1), 32'd0);
        check("reset result_valid", {31'd0, rv0}, 32'd0);

        // Single matching case: result one cycle after beat 15.
        send_case(0, match_case(), 0);
        @(negedge clk);
        check("first result_valid", {31'd0, rv0}, 32'd1);
        check("first correct", {31'd0, corr0}, 32'd1);
        check("first recent", 32'(recent0), 32'd1);
        check("first num_cases", nc0, 32'd1);

        // Mismatch on neuron 7, then five matches through a 4-deep window.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            c = match_case();
            if (i == 0) c.a = c.y ^ 16'h0080;
            send_case(0, c, 0);
            @(negedge clk);
            check($sformatf("window recent %0d", i), 32'(recent0), exp_recent[i]);
            check($sformatf("window full %0d", i), {31'd0, wf0}, exp_full[i]);
        end

        // Epoch rollover with three cases per epoch.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_case(0, match_case(), 0);
            @(negedge clk);
            if (i == 2) begin
                check("epoch_done pulse", {31'd0, ed0}, 32'd1);
                check("epoch advanced", {16'd0, ep0}, 32'd2);
                check("epoch_correct final", ec0, 32'd3);
                @(negedge clk);
                check("epoch_correct cleared", ec0, 32'd0);
                check("epoch_done single", {31'd0, ed0}, 32'd0);
            end
            if (i >= 3) check($sformatf("total_correct %0d", i), tc0, i + 1);
        end

        // Argmax: index 12 is out of the class range; tie resolves to the lower index.
        c.act = '0;
        for (int i = 0; i < N_OUT; i++) c.act[i*W +: W] = W'(10);
        c.act[3*W +: W]  = W'(100);
        c.act[12*W +: W] = W'(4000);
        c.y = 16'h0008;
        c.a = c.y;
        send_case(1, c, 0);
        @(negedge clk);
        check("argmax excludes idx 12", {31'd0, corr1}, 32'd1);
        c.act[5*W +: W] = W'(100);
        c.y = 16'h0020;
        send_case(1, c, 0);
        @(negedge clk);
        check("argmax tie lower idx", {31'd0, corr1}, 32'd0);

        // Reset after 6 of 16 beats discards the partial case.
        do_reset();
        in_valid0 = 1'b1; a0 = 1'b1; y0 = 1'b0; act0 = '0;
        repeat (6) begin @(posedge clk); #1; end
        do_reset();
        send_case(0, match_case(), 0);
        repeat (3) @(negedge clk);
        check("post-reset num_cases", nc0, 32'd1);
        check("post-reset epoch", {16'd0, ep0}, 32'd1);

        // in_valid toggling every cycle.
        send_case(0, match_case(), 100);
        @(negedge clk);
        check("gapped result_valid", {31'd0, rv0}, 32'd1);
        check("gapped correct", {31'd0, corr0}, 32'd1);
        c = match_case();
        c.a = c.y ^ 16'h8000;
        send_case(0, c, 100);
        @(negedge clk);
        check("gapped mismatch", {31'd0, corr0}, 32'd0);

        // Random traffic with random gaps, back-to-back and idle spacing mixed.
        for (int i = 0; i < 80; i++) begin
            int d;
            d = int'($urandom_range(1));
            send_case(d, rand_case(d), int'($urandom_range(40)));
            if ($urandom_range(3) == 0) begin
                repeat (int'($urandom_range(1, 3))) begin @(posedge clk); #1; end
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
